// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin icache/dcache arbiter for a single word-wide memory port
// Serialises whole-line refills and write-backs as word beats and returns assembled lines.
module mem_arbiter #(
    parameter int ADDR_WID  = 32,
    parameter int WORD_WID  = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req,
    input  logic [ADDR_WID-1:0]           i_addr,
    output logic                          i_done,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_WID-1:0]           d_addr,
    input  logic [WORD_WID*BURST_LEN-1:0] d_wline,
    output logic                          d_done,
    output logic [WORD_WID*BURST_LEN-1:0] line_out,
    output logic                          busy,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_WID-1:0]           mem_addr,
    output logic [WORD_WID-1:0]           mem_wdata,
    input  logic                          mem_ack,
    input  logic [WORD_WID-1:0]           mem_rdata
);
    localparam int LINE_WID = WORD_WID * BURST_LEN;
    localparam int OFF      = $clog2(4 * BURST_LEN);
    localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state;
    logic                owner_d;       // 1 = dcache owns the current transfer
    logic                last_grant_d;  // 1 = dcache was served last
    logic                we_q;
    logic [ADDR_WID-1:0] base;
    logic [LINE_WID-1:0] wline;
    logic [LINE_WID-1:0] line_buf;
    logic [LINE_WID-1:0] line_merge;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   next_beat;
    logic [ADDR_WID-1:0] next_addr;
    logic [ADDR_WID-1:0] i_base;
    logic [ADDR_WID-1:0] d_base;
    logic                grant_d;
    logic                unused_addr_bits;

    assign i_base           = {i_addr[ADDR_WID-1:OFF], {OFF{1'b0}}};
    assign d_base           = {d_addr[ADDR_WID-1:OFF], {OFF{1'b0}}};
    assign unused_addr_bits = ^{i_addr[OFF-1:0], d_addr[OFF-1:0]};

    always_comb begin
        grant_d    = d_req && (!i_req || !last_grant_d);
        next_beat  = beat + 1'b1;
        next_addr  = base + (ADDR_WID'(next_beat) << 2);
        line_merge = line_buf;
        line_merge[int'(beat)*WORD_WID +: WORD_WID] = mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            i_done       <= 1'b0;
            d_done       <= 1'b0;
            busy         <= 1'b0;
            line_out     <= '0;
            last_grant_d <= 1'b0;
            owner_d      <= 1'b0;
            we_q         <= 1'b0;
            base         <= '0;
            wline        <= '0;
            line_buf     <= '0;
            beat         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner_d <= grant_d;
                        base    <= grant_d ? d_base : i_base;
                        we_q    <= grant_d && d_we;
                        if (grant_d && d_we)
                            wline <= d_wline;
                        beat    <= '0;
                        busy    <= 1'b1;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // First ACCESS cycle loads beat 0 onto the port; acks before that are ignored.
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= we_q;
                        mem_addr  <= base;
                        mem_wdata <= wline[WORD_WID-1:0];
                    end else if (mem_ack) begin
                        if (!we_q)
                            line_buf <= line_merge;
                        if (beat == LAST_BEAT) begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            state   <= RESP;
                            if (owner_d)
                                d_done <= 1'b1;
                            else
                                i_done <= 1'b1;
                            if (!we_q)
                                line_out <= line_merge;
                        end else begin
                            beat      <= next_beat;
                            mem_addr  <= next_addr;
                            mem_wdata <= wline[int'(next_beat)*WORD_WID +: WORD_WID];
                        end
                    end
                end
                RESP: begin
                    i_done       <= 1'b0;
                    d_done       <= 1'b0;
                    last_grant_d <= owner_d;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         i_req, d_req, d_we;
    logic [31:0]  i_addr, d_addr;
    logic [127:0] d_wline;
    logic         i_done, d_done, busy;
    logic [127:0] line_out;
    logic         mem_req, mem_we, mem_ack;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wline(d_wline), .d_done(d_done),
        .line_out(line_out), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          cyc;
        int          hold;
        bit          stable;
    } beat_t;

    beat_t        obs_q[$];
    logic [64:0]  exp_q[$];
    int           pass_cnt = 0;
    int           total_cnt = 0;
    int           done_cyc, done_who, req_edge;
    logic [127:0] done_line;

    // Memory model: acks each beat after wait_cfg wait cycles, read data = seed + word index.
    int          wait_cfg = 0;
    int          wcnt = 0;
    logic [31:0] seed = 32'h0;
    initial begin
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req && wcnt == wait_cfg) begin
                mem_ack = 1'b1;
                mem_rdata = seed + {30'b0, mem_addr[3:2]};
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt = mem_req ? wcnt + 1 : 0;
            end
        end
    end

    function automatic logic [127:0] mk_line(input logic [31:0] s);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = s + k;
        return l;
    endfunction

    // Observes one transfer until the first done pulse; records beats, drops the owner's request.
    task automatic run_burst(input int max_cyc, input int drop_after);
        int hold = 0;
        int nb = 0;
        bit st = 1'b1;
        logic [31:0] a0 = 32'h0, w0 = 32'h0;
        done_cyc = -1;
        done_who = -1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk); #1;
            if (mem_req) begin
                if (hold == 0) begin a0 = mem_addr; w0 = mem_wdata; st = 1'b1; end
                else if (mem_addr !== a0 || mem_wdata !== w0) st = 1'b0;
                hold++;
                if (mem_ack) begin
                    obs_q.push_back('{mem_addr, mem_we, mem_wdata, cyc, hold, st});
                    hold = 0;
                    nb++;
                    if (nb == drop_after) i_req = 1'b0;
                end
            end
            if (i_done || d_done) begin
                done_cyc  = cyc;
                done_who  = d_done ? 1 : 0;
                done_line = line_out;
                if (i_done) i_req = 1'b0;
                if (d_done) d_req = 1'b0;
                return;
            end
        end
    endtask

    task automatic push_beats(input logic [31:0] base, input logic we, input logic [127:0] wl);
        for (int k = 0; k < 4; k++)
            exp_q.push_back({base + 32'(4*k), we, we ? wl[k*32 +: 32] : 32'h0});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total_cnt++;
        if ({mem_req, mem_we, i_done, d_done, busy} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000", {mem_req, mem_we, i_done, d_done, busy});
        else pass_cnt++;
        total_cnt++;
        if ({mem_addr, mem_wdata, line_out} !== 192'h0)
            $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, line_out});
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int first_done;
        logic [64:0] got;
        @(negedge clk); #1;
        seed = 32'h10; d_we = 1'b0; d_addr = 32'h4000; i_addr = 32'h5000;
        i_req = 1'b1; d_req = 1'b1; req_edge = cyc + 1;
        obs_q.delete(); exp_q.delete();
        push_beats(32'h4000, 1'b0, 128'h0);
        run_burst(40, 0);
        total_cnt++;
        if (done_who !== 1) $display("FAIL rr_first_owner got %0d want 1", done_who); else pass_cnt++;
        total_cnt++;
        if (done_cyc !== req_edge + 5) $display("FAIL rr_first_latency got %0d want %0d", done_cyc, req_edge + 5); else pass_cnt++;
        total_cnt++;
        if (done_line !== mk_line(32'h10)) $display("FAIL rr_dline got %h want %h", done_line, mk_line(32'h10)); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            got = (k < obs_q.size()) ? {obs_q[k].addr, obs_q[k].we, 32'h0} : 'x;
            total_cnt++;
            if (got !== exp_q[k]) $display("FAIL rr_dbeat%0d got %h want %h", k, got, exp_q[k]); else pass_cnt++;
        end
        first_done = done_cyc;
        obs_q.delete();
        run_burst(40, 0);
        total_cnt++;
        if (done_who !== 0) $display("FAIL rr_second_owner got %0d want 0", done_who); else pass_cnt++;
        total_cnt++;
        if (done_cyc - first_done !== 7) $display("FAIL rr_gap got %0d want 7", done_cyc - first_done); else pass_cnt++;
        total_cnt++;
        if (obs_q.size() == 0 || obs_q[0].addr !== 32'h5000)
            $display("FAIL rr_ibase got %0d beats want first addr 5000", obs_q.size());
        else pass_cnt++;
        @(negedge clk); #1;
        i_req = 1'b1; d_req = 1'b1;
        run_burst(40, 0);
        total_cnt++;
        if (done_who !== 1) $display("FAIL rr_third_owner got %0d want 1", done_who); else pass_cnt++;
        run_burst(40, 0);
        total_cnt++;
        if (done_who !== 0) $display("FAIL rr_fourth_owner got %0d want 0", done_who); else pass_cnt++;
    endtask

    task automatic test_icache_read();
        logic [64:0] got;
        @(negedge clk); #1;
        seed = 32'hA0; i_addr = 32'h1004; i_req = 1'b1; req_edge = cyc + 1;
        obs_q.delete(); exp_q.delete();
        push_beats(32'h1000, 1'b0, 128'h0);
        run_burst(40, 0);
        for (int k = 0; k < 4; k++) begin
            got = (k < obs_q.size()) ? {obs_q[k].addr, obs_q[k].we, 32'h0} : 'x;
            total_cnt++;
            if (got !== exp_q[k]) $display("FAIL icache_beat%0d got %h want %h", k, got, exp_q[k]); else pass_cnt++;
        end
        total_cnt++;
        if (obs_q.size() == 0 || obs_q[0].cyc !== req_edge + 1)
            $display("FAIL icache_first_beat got %0d beats want beat0 at cycle %0d", obs_q.size(), req_edge + 1);
        else pass_cnt++;
        total_cnt++;
        if (done_who !== 0 || done_cyc !== req_edge + 5)
            $display("FAIL icache_done got owner %0d cycle %0d want owner 0 cycle %0d", done_who, done_cyc, req_edge + 5);
        else pass_cnt++;
        total_cnt++;
        if (done_line !== 128'h000000A3_000000A2_000000A1_000000A0)
            $display("FAIL icache_line got %h want 000000a3000000a2000000a1000000a0", done_line);
        else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++;
        if ({i_done, busy} !== 2'b00) $display("FAIL icache_pulse_end got %b want 00", {i_done, busy}); else pass_cnt++;
    endtask

    task automatic test_dcache_writeback();
        logic [64:0] got;
        wait_cfg = 2;
        @(negedge clk); #1;
        d_we = 1'b1; d_addr = 32'h2008;
        d_wline = 128'h44440003_33330002_22220001_11110000;
        d_req = 1'b1; req_edge = cyc + 1;
        obs_q.delete(); exp_q.delete();
        push_beats(32'h2000, 1'b1, d_wline);
        run_burst(80, 0);
        for (int k = 0; k < 4; k++) begin
            got = (k < obs_q.size()) ? {obs_q[k].addr, obs_q[k].we, obs_q[k].wdata} : 'x;
            total_cnt++;
            if (got !== exp_q[k]) $display("FAIL wb_beat%0d got %h want %h", k, got, exp_q[k]); else pass_cnt++;
            total_cnt++;
            if (k >= obs_q.size() || obs_q[k].hold !== 3 || !obs_q[k].stable)
                $display("FAIL wb_hold%0d got %0d beats want 3 stable cycles per beat", k, obs_q.size());
            else pass_cnt++;
        end
        total_cnt++;
        if (done_who !== 1 || done_cyc !== req_edge + 13)
            $display("FAIL wb_done got owner %0d cycle %0d want owner 1 cycle %0d", done_who, done_cyc, req_edge + 13);
        else pass_cnt++;
        total_cnt++;
        if (done_line !== 128'h000000A3_000000A2_000000A1_000000A0)
            $display("FAIL wb_line_kept got %h want 000000a3000000a2000000a1000000a0", done_line);
        else pass_cnt++;
        wait_cfg = 0;
        d_we = 1'b0;
    endtask

    task automatic test_drop_mid_burst();
        @(negedge clk); #1;
        seed = 32'h50; i_addr = 32'h6010; i_req = 1'b1; req_edge = cyc + 1;
        obs_q.delete();
        run_burst(40, 2);
        total_cnt++;
        if (obs_q.size() !== 4) $display("FAIL drop_beats got %0d want 4", obs_q.size()); else pass_cnt++;
        total_cnt++;
        if (done_who !== 0 || done_cyc !== req_edge + 5)
            $display("FAIL drop_done got owner %0d cycle %0d want owner 0 cycle %0d", done_who, done_cyc, req_edge + 5);
        else pass_cnt++;
        total_cnt++;
        if (done_line !== mk_line(32'h50)) $display("FAIL drop_line got %h want %h", done_line, mk_line(32'h50)); else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        bit found = 1'b0;
        logic [64:0] got;
        @(negedge clk); #1;
        i_addr = 32'h7000; i_req = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk); #1;
            if (mem_req && mem_addr === 32'h7008) found = 1'b1;
        end
        total_cnt++;
        if (!found) $display("FAIL rst_mid_reach got no beat2 want beat2 within 20 cycles"); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({mem_req, mem_we, busy, i_done, d_done} !== 5'b0)
            $display("FAIL rst_mid_ctrl got %b want 00000", {mem_req, mem_we, busy, i_done, d_done});
        else pass_cnt++;
        total_cnt++;
        if ({mem_addr, mem_wdata, line_out} !== 192'h0)
            $display("FAIL rst_mid_data got %h want 0", {mem_addr, mem_wdata, line_out});
        else pass_cnt++;
        i_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        seed = 32'h70; d_addr = 32'h3000; d_req = 1'b1; req_edge = cyc + 1;
        obs_q.delete(); exp_q.delete();
        push_beats(32'h3000, 1'b0, 128'h0);
        run_burst(40, 0);
        for (int k = 0; k < 4; k++) begin
            got = (k < obs_q.size()) ? {obs_q[k].addr, obs_q[k].we, 32'h0} : 'x;
            total_cnt++;
            if (got !== exp_q[k]) $display("FAIL rst_fresh_beat%0d got %h want %h", k, got, exp_q[k]); else pass_cnt++;
        end
        total_cnt++;
        if (done_who !== 1 || done_cyc !== req_edge + 5)
            $display("FAIL rst_fresh_done got owner %0d cycle %0d want owner 1 cycle %0d", done_who, done_cyc, req_edge + 5);
        else pass_cnt++;
        total_cnt++;
        if (done_line !== mk_line(32'h70)) $display("FAIL rst_fresh_line got %h want %h", done_line, mk_line(32'h70)); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wline = 128'h0;
        test_reset();
        test_round_robin();
        test_icache_read();
        test_dcache_writeback();
        test_drop_mid_burst();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
